mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: four-core round-robin arbiter in front of a single shared DRAM port.
// A winning request is latched and carried through ACCESS (one DRAM strobe),
// WAIT (MEM_LAT read-latency cycles, reads only) and DONE (one-cycle done pulse).
// Optional build macro: MEM_ARB_STATS_EN adds the 16-bit saturating 'conflicts'
// output, which counts busy cycles during which a non-granted core is requesting.
module mem_arbiter #(
    parameter int unsigned MEM_LAT = 2,
    parameter int unsigned DATA_W  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [3:0]            req,
    input  logic [3:0]            we,
    input  logic [4*DATA_W-1:0]   addr,
    input  logic [4*DATA_W-1:0]   wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [3:0]            gnt,
    output logic [3:0]            done,
    output logic [DATA_W-1:0]     rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [DATA_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  busy
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]           conflicts
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    // WAIT counts down from MEM_LAT-1 to 0, giving exactly MEM_LAT cycles.
    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t              state_q;
    logic [1:0]          last_q;
    logic [1:0]          win_q;
    logic [3:0]          cnt_q;
    logic [3:0]          gnt_q;
    logic [3:0]          done_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                mem_en_q;
    logic                mem_we_q;
    logic [DATA_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                busy_q;

    logic [1:0]          win_d;
    logic [1:0]          idx_d;
    logic                found_d;
    logic [DATA_W-1:0]   sel_addr_d;
    logic [DATA_W-1:0]   sel_wdata_d;
    logic                sel_we_d;

    // Round-robin pick: scan from last+1 upward (mod 4), first requester wins.
    always_comb begin
        win_d   = last_q;
        idx_d   = last_q;
        found_d = 1'b0;
        for (int unsigned i = 1; i <= 4; i++) begin
            idx_d = last_q + 2'(i);
            if (!found_d && req[idx_d]) begin
                win_d   = idx_d;
                found_d = 1'b1;
            end
        end
    end

    // Select the winning core's request fields for latching.
    always_comb begin
        sel_addr_d  = addr[win_d*DATA_W +: DATA_W];
        sel_wdata_d = wdata[win_d*DATA_W +: DATA_W];
        sel_we_d    = we[win_d];
    end

    // Transaction FSM; every output is registered alongside the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= 2'd3;
            win_q       <= 2'd0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            rdata_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= '0;
                    if (|req) begin
                        win_q       <= win_d;
                        gnt_q       <= 4'b0001 << win_d;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= sel_we_d;
                        mem_addr_q  <= sel_addr_d;
                        mem_wdata_q <= sel_wdata_d;
                        busy_q      <= 1'b1;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    // mem_we_q still holds the latched write flag during ACCESS.
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    if (mem_we_q) begin
                        done_q  <= gnt_q;
                        state_q <= DONE;
                    end else begin
                        cnt_q   <= CNT_INIT;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        rdata_q <= mem_rdata;
                        done_q  <= gnt_q;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    done_q  <= '0;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                    last_q  <= win_q;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

`ifdef MEM_ARB_STATS_EN
    logic [15:0] conflicts_q;

    // Count busy cycles in which some non-granted core is requesting; saturate.
    always_ff @(posedge clock) begin
        if (reset) begin
            conflicts_q <= '0;
        end else if (busy_q && |(req & ~gnt_q) && conflicts_q != '1) begin
            conflicts_q <= conflicts_q + 16'd1;
        end
    end

    assign conflicts = conflicts_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter (MEM_LAT=2, DATA_W=16).
// Expected done/rdata pairs are queued when requests are driven and compared
// when the DUT pulses done. Define MEM_ARB_STATS_EN to also check 'conflicts'.
module tb_mem_arbiter;

    localparam int unsigned LAT = 2;
    localparam int unsigned DW  = 16;

    logic              clock = 1'b0;
    logic              reset;
    logic [3:0]        req;
    logic [3:0]        we;
    logic [4*DW-1:0]   addr;
    logic [4*DW-1:0]   wdata;
    logic [DW-1:0]     mem_rdata;
    logic [3:0]        gnt;
    logic [3:0]        done;
    logic [DW-1:0]     rdata;
    logic              mem_en;
    logic              mem_we;
    logic [DW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              busy;
`ifdef MEM_ARB_STATS_EN
    logic [15:0]       conflicts;
`endif

    mem_arbiter #(.MEM_LAT(LAT), .DATA_W(DW)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .mem_rdata (mem_rdata),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy)
`ifdef MEM_ARB_STATS_EN
        ,
        .conflicts (conflicts)
`endif
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // DRAM model: write on strobe, read data appears LAT cycles after the strobe edge.
    logic [DW-1:0] dram  [0:255];
    logic [DW-1:0] rpipe [0:LAT-1];

    always @(posedge clock) begin
        if (mem_en && mem_we) dram[mem_addr[7:0]] <= mem_wdata;
        rpipe[0] <= (mem_en && !mem_we) ? dram[mem_addr[7:0]] : 16'hDEAD;
        for (int i = 1; i < int'(LAT); i++) rpipe[i] <= rpipe[i-1];
    end
    assign mem_rdata = rpipe[LAT-1];

    typedef struct {
        logic [3:0]    done;
        logic [DW-1:0] rdata;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    // Scoreboard monitor and cycle invariants, sampled mid-cycle.
    always @(negedge clock) begin
        if (!reset) begin
            check("busy_eq_gnt", 32'(busy), 32'(|gnt));
            check("we_without_en", 32'(mem_we & ~mem_en), 32'd0);
            if (done != 4'b0000) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("sb_done", 32'(done), 32'(mon_e.done));
                    check("sb_rdata", 32'(rdata), 32'(mon_e.rdata));
                    check("sb_gnt_at_done", 32'(gnt), 32'(done));
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [3:0] d, input logic [DW-1:0] r);
        exp_t e;
        e.done  = d;
        e.rdata = r;
        sb.push_back(e);
    endtask

    task automatic issue(input int core, input logic w, input logic [DW-1:0] a, input logic [DW-1:0] wd);
        req[core]              = 1'b1;
        we[core]               = w;
        addr[core*DW +: DW]    = a;
        wdata[core*DW +: DW]   = wd;
    endtask

    // Wait (bounded) for the next done pulse; optionally drop that core's request.
    task automatic wait_done(input string tag, input logic [3:0] exp, input bit drop);
        int n = 0;
        do begin
            step();
            @(negedge clock);
            n++;
        end while (done == 4'b0000 && n < 40);
        check(tag, 32'(done), 32'(exp));
        if (drop) begin
            step();
            req = req & ~exp;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        we    = '0;
        step();
        step();
        @(negedge clock);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        step();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) dram[i] = 16'(i * 3);
        dram[8'h40] = 16'hBEEF;
        for (int i = 0; i < 4; i++) dram[8'h80 + i] = 16'hA000 + 16'(i);
        reset = 1'b1;
        req   = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        do_reset();

        // Core 1 read of 0x0040, DRAM returns 0xBEEF at cycle 2+LAT.
        issue(1, 1'b0, 16'h0040, 16'h0000);
        push(4'b0010, 16'hBEEF);
        for (int c = 1; c <= 4; c++) begin
            step();
            @(negedge clock);
            check("rd_gnt", 32'(gnt), 32'h2);
            check("rd_mem_en", 32'(mem_en), 32'(c == 1));
            check("rd_done_cycle", 32'(done), (c == 4) ? 32'h2 : 32'h0);
            if (c == 1) check("rd_mem_addr", 32'(mem_addr), 32'h40);
        end
        step();
        req = '0;
        @(negedge clock);
        check("rd_idle_busy", 32'(busy), 32'd0);
        check("rd_rdata_hold", 32'(rdata), 32'hBEEF);

        // Core 2 write 0x1234 to 0x0010: done at cycle 2, rdata unchanged.
        issue(2, 1'b1, 16'h0010, 16'h1234);
        push(4'b0100, 16'hBEEF);
        for (int c = 1; c <= 2; c++) begin
            step();
            @(negedge clock);
            check("wr_mem_en", 32'(mem_en), 32'(c == 1));
            check("wr_mem_we", 32'(mem_we), 32'(c == 1));
            check("wr_done_cycle", 32'(done), (c == 2) ? 32'h4 : 32'h0);
            if (c == 1) begin
                check("wr_mem_addr", 32'(mem_addr), 32'h10);
                check("wr_mem_wdata", 32'(mem_wdata), 32'h1234);
            end
        end
        step();
        req = '0;

        // Core 0 reads back the written location.
        issue(0, 1'b0, 16'h0010, 16'h0000);
        push(4'b0001, 16'h1234);
        wait_done("rb_done", 4'b0001, 1'b1);

        // All four cores held: grant order 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < 4; i++) issue(i, 1'b0, 16'h0080 + 16'(i), 16'h0000);
        for (int k = 0; k < 5; k++) push(4'b0001 << (k % 4), 16'hA000 + 16'(k % 4));
        for (int k = 0; k < 5; k++) wait_done("rr_order", 4'b0001 << (k % 4), 1'b0);
        step();
        req = '0;

        // Reset during a core 0 read in WAIT aborts it without done.
        do_reset();
        issue(0, 1'b0, 16'h0040, 16'h0000);
        step();
        step();
        reset = 1'b1;
        @(negedge clock);
        check("ab_in_wait_busy", 32'(busy), 32'd1);
        step();
        reset = 1'b0;
        req   = '0;
        @(negedge clock);
        check("ab_busy", 32'(busy), 32'd0);
        check("ab_mem_en", 32'(mem_en), 32'd0);
        check("ab_gnt", 32'(gnt), 32'd0);
        for (int c = 0; c < 4; c++) begin
            check("ab_no_done", 32'(done), 32'd0);
            step();
            @(negedge clock);
        end
        // Post-abort: last was reset, so core 0 beats core 2.
        issue(0, 1'b1, 16'h0020, 16'h5555);
        issue(2, 1'b1, 16'h0021, 16'h6666);
        push(4'b0001, 16'h0000);
        push(4'b0100, 16'h0000);
        wait_done("ab_first", 4'b0001, 1'b1);
        wait_done("ab_second", 4'b0100, 1'b1);

        // Core 3 read, request dropped during WAIT: done still at cycle 2+LAT.
        issue(3, 1'b0, 16'h0021, 16'h0000);
        push(4'b1000, 16'h6666);
        for (int c = 1; c <= 4; c++) begin
            step();
            if (c == 2) req[3] = 1'b0;
            @(negedge clock);
            check("drop_done_cycle", 32'(done), (c == 4) ? 32'h8 : 32'h0);
        end
        step();

`ifdef MEM_ARB_STATS_EN
        // Cores 0 and 1 together: four contended busy cycles before core 1 wins.
        do_reset();
        check("st_rst_conflicts", 32'(conflicts), 32'd0);
        issue(0, 1'b0, 16'h0080, 16'h0000);
        issue(1, 1'b0, 16'h0081, 16'h0000);
        push(4'b0001, 16'hA000);
        push(4'b0010, 16'hA001);
        wait_done("st_first", 4'b0001, 1'b1);
        step();
        @(negedge clock);
        check("st_gnt1", 32'(gnt), 32'h2);
        check("st_conflicts", 32'(conflicts), 32'd4);
        wait_done("st_second", 4'b0010, 1'b1);
`endif

        step();
        step();
        check("sb_leftover", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
